icap_word_downsizer: RTL and testbench



---
 rtl/icap_word_downsizer.sv | 135 +++++++++++++
 tb/tb_icap_word_downsizer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icap_word_downsizer.sv
// Splits wide AXI-Stream partial-bitstream beats into ICAP-width words, with
// optional per-byte bit reversal, tkeep validation and a readback word counter.
module icap_word_downsizer #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 32,
  parameter bit BIT_SWAP  = 1'b1
) (
  input  logic                    sys_clk,
  input  logic                    sys_reset,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [IN_WIDTH-1:0]     s_axis_tdata,
  input  logic [IN_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    m_word_valid,
  input  logic                    m_word_ready,
  output logic [OUT_WIDTH-1:0]    m_word_data,
  output logic                    m_word_last,
  input  logic                    cnt_clear,
  output logic [31:0]             word_count,
  output logic                    keep_err,
  output logic                    busy
);
  localparam int N  = IN_WIDTH / OUT_WIDTH;
  localparam int KB = OUT_WIDTH / 8;
  localparam int CW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t               state_p0, state_d;
  logic [CW-1:0]        idx_p0, idx_d;
  logic [CW-1:0]        nlanes_p0, nlanes_c;
  logic                 last_p0;
  logic [OUT_WIDTH-1:0] lanes_p0 [N];
  logic                 keep_bad_c, gap_c;
  logic                 final_lane, accept, load, word_hs;
  logic [OUT_WIDTH-1:0] cur_lane;

  function automatic logic [OUT_WIDTH-1:0] bit_swap(input logic [OUT_WIDTH-1:0] w);
    logic [OUT_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < KB; b++)
      for (int i = 0; i < 8; i++)
        r[8*b+i] = w[8*b+7-i];
    return r;
  endfunction

  // Leading fully-kept lanes form the payload; anything irregular flags keep_err.
  always_comb begin
    nlanes_c   = '0;
    keep_bad_c = 1'b0;
    gap_c      = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (&s_axis_tkeep[k*KB +: KB]) begin
        if (gap_c) keep_bad_c = 1'b1;
        else       nlanes_c   = nlanes_c + CW'(1);
      end else begin
        gap_c = 1'b1;
        if (|s_axis_tkeep[k*KB +: KB]) keep_bad_c = 1'b1;
      end
    end
    if (nlanes_c == '0) keep_bad_c = 1'b1;
  end

  assign final_lane    = (idx_p0 == nlanes_p0 - CW'(1));
  assign m_word_valid  = (state_p0 == DRAIN);
  assign busy          = (state_p0 == DRAIN);
  assign s_axis_tready = !sys_reset &&
                         ((state_p0 == EMPTY) || (m_word_ready && final_lane));
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign load          = accept && (nlanes_c != '0);
  assign word_hs       = m_word_valid && m_word_ready;

  always_comb begin
    state_d = state_p0;
    idx_d   = idx_p0;
    case (state_p0)
      EMPTY: begin
        if (load) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (word_hs) begin
          if (!final_lane) begin
            idx_d = idx_p0 + CW'(1);
          end else if (load) begin
            idx_d = '0;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Stage p0: control state, counters and error flag
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_p0   <= EMPTY;
      idx_p0     <= '0;
      word_count <= '0;
      keep_err   <= 1'b0;
    end else begin
      state_p0 <= state_d;
      idx_p0   <= idx_d;
      if (cnt_clear)
        word_count <= '0;
      else if (word_hs && !(&word_count))
        word_count <= word_count + 32'd1;
      if (accept && keep_bad_c)
        keep_err <= 1'b1;
      else if (cnt_clear)
        keep_err <= 1'b0;
    end
  end

  // Stage p0: held beat payload, only meaningful while draining
  always_ff @(posedge sys_clk) begin
    if (load) begin
      nlanes_p0 <= nlanes_c;
      last_p0   <= s_axis_tlast;
      for (int k = 0; k < N; k++)
        lanes_p0[k] <= s_axis_tdata[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign cur_lane    = lanes_p0[idx_p0[IW-1:0]];
  assign m_word_data = BIT_SWAP ? bit_swap(cur_lane) : cur_lane;
  assign m_word_last = m_word_valid && last_p0 && final_lane;

endmodule

// File: tb/tb_icap_word_downsizer.sv
// Directed bench for icap_word_downsizer: swap/non-swap builds, back-to-back
// beats, output stalls, tkeep handling, mid-drain reset and counter clear.
module tb_icap_word_downsizer;
  logic         sys_clk = 1'b0;
  logic         sys_reset;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic         m_word_valid, m_word_ready, m_word_last;
  logic [31:0]  m_word_data;
  logic         cnt_clear, keep_err, busy;
  logic [31:0]  word_count;

  logic         tvalid2, tready2, tlast2, valid2, ready2, last2, clear2, kerr2, busy2;
  logic [255:0] tdata2;
  logic [31:0]  tkeep2, data2, count2;

  logic [31:0]  lane_v [8];
  logic [47:0]  pat = 48'hB4E2_1D96_C35A;
  int           checks = 0;
  int           errors = 0;

  always #5 sys_clk = ~sys_clk;

  icap_word_downsizer #(.IN_WIDTH(256), .OUT_WIDTH(32), .BIT_SWAP(1'b1)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_word_valid(m_word_valid), .m_word_ready(m_word_ready),
    .m_word_data(m_word_data), .m_word_last(m_word_last),
    .cnt_clear(cnt_clear), .word_count(word_count), .keep_err(keep_err), .busy(busy)
  );

  icap_word_downsizer #(.IN_WIDTH(256), .OUT_WIDTH(32), .BIT_SWAP(1'b0)) dut_noswap (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .s_axis_tvalid(tvalid2), .s_axis_tready(tready2),
    .s_axis_tdata(tdata2), .s_axis_tkeep(tkeep2), .s_axis_tlast(tlast2),
    .m_word_valid(valid2), .m_word_ready(ready2),
    .m_word_data(data2), .m_word_last(last2),
    .cnt_clear(clear2), .word_count(count2), .keep_err(kerr2), .busy(busy2)
  );

  function automatic logic [31:0] swapref(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[(i & ~7) | (7 - (i & 7))];
    return r;
  endfunction

  function automatic logic [31:0] b2b_lane(input int b, input int k);
    return 32'hC300_0000 | (32'(b) << 8) | 32'(k);
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] keep, input logic last);
    for (int k = 0; k < 8; k++) s_axis_tdata[32*k +: 32] = lane_v[k];
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic send(input logic [31:0] keep, input logic last);
    drive_beat(keep, last);
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(input int n, input logic last);
    for (int w = 0; w < n; w++) begin
      @(negedge sys_clk);
      chk1($sformatf("drain_valid%0d", w), m_word_valid, 1'b1);
      chk32($sformatf("drain_data%0d", w), m_word_data, swapref(lane_v[w]));
      chk1($sformatf("drain_last%0d", w), m_word_last, last && (w == n - 1));
      tick();
    end
    @(negedge sys_clk);
    chk1("drain_idle", m_word_valid, 1'b0);
    tick();
  endtask

  initial begin
    int widx;
    int bi;
    logic acc_exp;
    sys_reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; m_word_ready = 1'b1; cnt_clear = 1'b0;
    tvalid2 = 1'b0; tdata2 = '0; tkeep2 = '0; tlast2 = 1'b0; ready2 = 1'b1; clear2 = 1'b0;
    tick(); tick();

    // reset state
    @(negedge sys_clk);
    chk1("rst_tready", s_axis_tready, 1'b0);
    chk1("rst_valid", m_word_valid, 1'b0);
    chk1("rst_last", m_word_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_kerr", keep_err, 1'b0);
    chk32("rst_count", word_count, 32'd0);
    tick();
    sys_reset = 1'b0;
    @(negedge sys_clk);
    chk1("post_rst_tready", s_axis_tready, 1'b1);
    tick();

    // single full beat with the sync-word lane
    lane_v[0] = 32'hAA995566;
    for (int k = 1; k < 8; k++) lane_v[k] = 32'(k);
    send(32'hFFFF_FFFF, 1'b1);
    for (int w = 0; w < 8; w++) begin
      @(negedge sys_clk);
      chk1($sformatf("t1_valid%0d", w), m_word_valid, 1'b1);
      if (w == 0) chk32("t1_first", m_word_data, 32'h5599AA66);
      else        chk32($sformatf("t1_data%0d", w), m_word_data, swapref(32'(w)));
      chk1($sformatf("t1_last%0d", w), m_word_last, w == 7);
      chk1($sformatf("t1_busy%0d", w), busy, 1'b1);
      tick();
    end
    @(negedge sys_clk);
    chk1("t1_idle", m_word_valid, 1'b0);
    chk32("t1_count", word_count, 32'd8);
    tick();

    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    @(negedge sys_clk);
    chk32("clr_count", word_count, 32'd0);
    tick();

    // four back-to-back beats, no bubbles
    for (int k = 0; k < 8; k++) lane_v[k] = b2b_lane(0, k);
    drive_beat(32'hFFFF_FFFF, 1'b0);
    bi = 0;
    for (int c = 0; c < 34; c++) begin
      @(negedge sys_clk);
      if (c == 0) begin
        chk1("b2b_tready0", s_axis_tready, 1'b1);
        chk1("b2b_valid0", m_word_valid, 1'b0);
      end else if (c <= 32) begin
        chk1($sformatf("b2b_valid%0d", c - 1), m_word_valid, 1'b1);
        chk32($sformatf("b2b_data%0d", c - 1), m_word_data, swapref(b2b_lane((c - 1) / 8, (c - 1) % 8)));
        chk1($sformatf("b2b_last%0d", c - 1), m_word_last, (c - 1) == 31);
        chk1($sformatf("b2b_tready%0d", c - 1), s_axis_tready, ((c - 1) % 8) == 7);
      end else begin
        chk1("b2b_end_valid", m_word_valid, 1'b0);
      end
      acc_exp = (c == 0) || (c >= 1 && c <= 32 && ((c - 1) % 8) == 7);
      tick();
      if (acc_exp && bi < 4) begin
        bi++;
        if (bi < 4) begin
          for (int k = 0; k < 8; k++) lane_v[k] = b2b_lane(bi, k);
          drive_beat(32'hFFFF_FFFF, bi == 3);
        end else begin
          s_axis_tvalid = 1'b0;
        end
      end
    end
    chk32("b2b_count", word_count, 32'd32);

    // output stalls from a fixed pseudo-random ready pattern
    for (int k = 0; k < 8; k++) lane_v[k] = 32'h9E3779B9 * 32'(k + 1);
    m_word_ready = 1'b0;
    send(32'hFFFF_FFFF, 1'b1);
    widx = 0;
    for (int c = 0; c < 60 && widx < 8; c++) begin
      m_word_ready = pat[c % 48];
      @(negedge sys_clk);
      chk1($sformatf("stl_valid%0d", c), m_word_valid, 1'b1);
      chk32($sformatf("stl_data%0d", c), m_word_data, swapref(lane_v[widx]));
      chk1($sformatf("stl_last%0d", c), m_word_last, widx == 7);
      chk1($sformatf("stl_tready%0d", c), s_axis_tready, m_word_ready && widx == 7);
      tick();
      if (m_word_ready) widx++;
    end
    chk32("stl_words", 32'(widx), 32'd8);
    m_word_ready = 1'b1;
    @(negedge sys_clk);
    chk1("stl_idle", m_word_valid, 1'b0);
    chk32("stl_count", word_count, 32'd40);
    tick();

    // tkeep handling
    for (int k = 0; k < 8; k++) lane_v[k] = 32'h0F1E_2D00 + 32'(k);
    send(32'h0000_0FFF, 1'b1);
    drain(3, 1'b1);
    chk1("k3_kerr", keep_err, 1'b0);
    chk32("k3_count", word_count, 32'd43);
    send(32'h0000_00F0, 1'b1);
    @(negedge sys_clk);
    chk1("kgap_valid", m_word_valid, 1'b0);
    chk1("kgap_busy", busy, 1'b0);
    chk1("kgap_kerr", keep_err, 1'b1);
    chk32("kgap_count", word_count, 32'd43);
    tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    @(negedge sys_clk);
    chk1("kclr_kerr", keep_err, 1'b0);
    tick();
    send(32'h0000_007F, 1'b1);
    drain(1, 1'b1);
    chk1("kpart_kerr", keep_err, 1'b1);
    chk32("kpart_count", word_count, 32'd1);

    // reset after three of eight words
    for (int k = 0; k < 8; k++) lane_v[k] = 32'h5A00_0000 + 32'(k * 3);
    send(32'hFFFF_FFFF, 1'b1);
    for (int w = 0; w < 3; w++) begin
      @(negedge sys_clk);
      chk32($sformatf("mr_data%0d", w), m_word_data, swapref(lane_v[w]));
      tick();
    end
    sys_reset = 1'b1;
    @(negedge sys_clk);
    chk1("mr_tready_in_rst", s_axis_tready, 1'b0);
    tick();
    sys_reset = 1'b0;
    @(negedge sys_clk);
    chk1("mr_valid", m_word_valid, 1'b0);
    chk1("mr_busy", busy, 1'b0);
    chk32("mr_count", word_count, 32'd0);
    chk1("mr_kerr", keep_err, 1'b0);
    chk1("mr_tready", s_axis_tready, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) lane_v[k] = 32'h6600_1100 + 32'(k);
    send(32'hFFFF_FFFF, 1'b1);
    drain(8, 1'b1);
    chk32("mr_count_after", word_count, 32'd8);

    // clear collides with a handshake
    for (int k = 0; k < 8; k++) lane_v[k] = 32'h7700_0000 + 32'(k);
    send(32'h0000_0FFF, 1'b0);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    @(negedge sys_clk);
    chk32("cc_count0", word_count, 32'd0);
    chk32("cc_data1", m_word_data, swapref(lane_v[1]));
    tick();
    @(negedge sys_clk);
    chk32("cc_data2", m_word_data, swapref(lane_v[2]));
    chk1("cc_last2", m_word_last, 1'b0);
    tick();
    @(negedge sys_clk);
    chk1("cc_idle", m_word_valid, 1'b0);
    chk32("cc_count2", word_count, 32'd2);
    tick();

    // clear collides with a bad-tkeep accept
    cnt_clear = 1'b1;
    send(32'h0000_00F0, 1'b0);
    cnt_clear = 1'b0;
    @(negedge sys_clk);
    chk1("ce_kerr", keep_err, 1'b1);
    chk32("ce_count", word_count, 32'd0);
    tick();

    // pass-through build
    tdata2[31:0] = 32'hAA995566;
    tkeep2 = 32'h0000_000F;
    tlast2 = 1'b0;
    ready2 = 1'b0;
    tvalid2 = 1'b1;
    tick();
    tvalid2 = 1'b0;
    @(negedge sys_clk);
    chk1("ns_valid", valid2, 1'b1);
    chk32("ns_data", data2, 32'hAA995566);
    chk1("ns_last", last2, 1'b0);
    tick();
    ready2 = 1'b1;
    @(negedge sys_clk);
    chk32("ns_data_stall", data2, 32'hAA995566);
    tick();
    @(negedge sys_clk);
    chk1("ns_idle", valid2, 1'b0);
    chk32("ns_count", count2, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
